video_window: RTL and testbench

- Single-clock, frame-synchronous window processor for the video-process path.
- Sits ahead of the scaler/FIFO stage, or directly on the output stream.
- Generalises the fixed crop block:
  - runtime-programmable window;
  - parametrised pixel width and channel count;
  - four modes: bypass, crop, mask and border-overlay;
  - configuration is shadowed and only takes effect at frame start.

---
 rtl/video_window.sv | 214 +++++++++++++++++++++
 tb/tb_video_window.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_window.sv
// rtl/video_window.sv - frame-synchronous window processor: bypass, crop, mask and border overlay
//
// Ports:
//   clk, rst_n          pixel clock, synchronous active-low reset
//   cfg_start_x/_y      first column/line inside the window (inclusive)
//   cfg_end_x/_y        column/line after the window (exclusive)
//   cfg_mode            0 bypass, 1 crop, 2 mask, 3 border
//   cfg_fill            fill / border colour
//   vi_vs, vi_de, vi_data   input video stream
//   vo_vs, vo_de, vo_data   output video stream, one clock behind the input
//   cfg_err             window latched for the current frame is empty/inverted
//   frame_cnt           frames started since reset (wraps)

module video_window #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 3,
    parameter int X_WIDTH    = 12,
    parameter int Y_WIDTH    = 12,
    parameter int BORDER_W   = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [X_WIDTH-1:0]               cfg_start_x,
    input  logic [Y_WIDTH-1:0]               cfg_start_y,
    input  logic [X_WIDTH-1:0]               cfg_end_x,
    input  logic [Y_WIDTH-1:0]               cfg_end_y,
    input  logic [1:0]                       cfg_mode,
    input  logic [DATA_WIDTH*CHANNELS-1:0]   cfg_fill,
    input  logic                             vi_vs,
    input  logic                             vi_de,
    input  logic [DATA_WIDTH*CHANNELS-1:0]   vi_data,
    output logic                             vo_vs,
    output logic                             vo_de,
    output logic [DATA_WIDTH*CHANNELS-1:0]   vo_data,
    output logic                             cfg_err,
    output logic [15:0]                      frame_cnt
);

    localparam int PW = DATA_WIDTH * CHANNELS;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_CROP   = 2'd1;
    localparam logic [1:0] MODE_MASK   = 2'd2;
    localparam logic [1:0] MODE_BORDER = 2'd3;

    localparam logic [X_WIDTH:0]   BW_X1 = (X_WIDTH+1)'(BORDER_W);
    localparam logic [Y_WIDTH:0]   BW_Y1 = (Y_WIDTH+1)'(BORDER_W);
    localparam logic [X_WIDTH-1:0] BW_X  = X_WIDTH'(BORDER_W);
    localparam logic [Y_WIDTH-1:0] BW_Y  = Y_WIDTH'(BORDER_W);
    localparam logic [X_WIDTH-1:0] X_MAX = '1;
    localparam logic [Y_WIDTH-1:0] Y_MAX = '1;

    // Input history
    logic vs_d;
    logic de_d;

    // Position of the next pixel in the frame
    logic [X_WIDTH-1:0] x;
    logic [Y_WIDTH-1:0] y;

    // Shadow configuration, only reloaded at frame start
    logic [X_WIDTH-1:0] sh_sx;
    logic [Y_WIDTH-1:0] sh_sy;
    logic [X_WIDTH-1:0] sh_ex;
    logic [Y_WIDTH-1:0] sh_ey;
    logic [1:0]         sh_mode;
    logic [PW-1:0]      sh_fill;

    logic vs_rise;
    logic new_err;

    // Configuration and position that apply to the pixel on this cycle.
    // On a frame-start cycle the pixel belongs to the new frame, so it sees
    // the incoming cfg_* and position (0,0) rather than the stale shadow.
    logic [X_WIDTH-1:0] act_sx;
    logic [Y_WIDTH-1:0] act_sy;
    logic [X_WIDTH-1:0] act_ex;
    logic [Y_WIDTH-1:0] act_ey;
    logic [1:0]         act_mode;
    logic [PW-1:0]      act_fill;
    logic               act_err;
    logic [X_WIDTH-1:0] cur_x;
    logic [Y_WIDTH-1:0] cur_y;

    logic               in_win;
    logic               on_edge;
    logic [X_WIDTH:0]   sx_in;
    logic [Y_WIDTH:0]   sy_in;
    logic [X_WIDTH-1:0] ex_in;
    logic [Y_WIDTH-1:0] ey_in;
    logic [1:0]         mode_eff;

    logic               nxt_de;
    logic [PW-1:0]      nxt_data;

    assign vs_rise = vi_vs & ~vs_d;
    assign new_err = (cfg_start_x >= cfg_end_x) | (cfg_start_y >= cfg_end_y);

    always_comb begin
        act_sx   = sh_sx;
        act_sy   = sh_sy;
        act_ex   = sh_ex;
        act_ey   = sh_ey;
        act_mode = sh_mode;
        act_fill = sh_fill;
        act_err  = cfg_err;
        cur_x    = x;
        cur_y    = y;
        if (vs_rise) begin
            act_sx   = cfg_start_x;
            act_sy   = cfg_start_y;
            act_ex   = cfg_end_x;
            act_ey   = cfg_end_y;
            act_mode = cfg_mode;
            act_fill = cfg_fill;
            act_err  = new_err;
            cur_x    = '0;
            cur_y    = '0;
        end
    end

    always_comb begin
        in_win = (cur_x >= act_sx) & (cur_x < act_ex) &
                 (cur_y >= act_sy) & (cur_y < act_ey);

        // Inner edges of the border ring. Start edges get one extra bit so
        // the sum cannot overflow; end edges clamp at zero instead of wrapping.
        sx_in = {1'b0, act_sx} + BW_X1;
        sy_in = {1'b0, act_sy} + BW_Y1;
        ex_in = (act_ex >= BW_X) ? (act_ex - BW_X) : '0;
        ey_in = (act_ey >= BW_Y) ? (act_ey - BW_Y) : '0;

        on_edge = in_win & (({1'b0, cur_x} < sx_in) | (cur_x >= ex_in) |
                            ({1'b0, cur_y} < sy_in) | (cur_y >= ey_in));

        // An invalid window degrades the whole frame to bypass
        mode_eff = act_err ? MODE_BYPASS : act_mode;
    end

    always_comb begin
        nxt_de   = vi_de;
        nxt_data = vi_data;
        case (mode_eff)
            MODE_CROP: begin
                nxt_de   = vi_de & in_win;
                nxt_data = vi_data;
            end
            MODE_MASK: begin
                nxt_data = in_win ? vi_data : act_fill;
            end
            MODE_BORDER: begin
                nxt_data = on_edge ? act_fill : vi_data;
            end
            default: begin
                nxt_de   = vi_de;
                nxt_data = vi_data;
            end
        endcase
        // Blank cycles always carry zero data
        if (!nxt_de) begin
            nxt_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_d      <= 1'b0;
            de_d      <= 1'b0;
            x         <= '0;
            y         <= '0;
            sh_sx     <= '0;
            sh_sy     <= '0;
            sh_ex     <= '0;
            sh_ey     <= '0;
            sh_mode   <= MODE_BYPASS;
            sh_fill   <= '0;
            cfg_err   <= 1'b0;
            frame_cnt <= '0;
            vo_vs     <= 1'b0;
            vo_de     <= 1'b0;
            vo_data   <= '0;
        end else begin
            vs_d    <= vi_vs;
            de_d    <= vi_de;
            vo_vs   <= vi_vs;
            vo_de   <= nxt_de;
            vo_data <= nxt_data;

            if (vs_rise) begin
                sh_sx     <= cfg_start_x;
                sh_sy     <= cfg_start_y;
                sh_ex     <= cfg_end_x;
                sh_ey     <= cfg_end_y;
                sh_mode   <= cfg_mode;
                sh_fill   <= cfg_fill;
                cfg_err   <= new_err;
                frame_cnt <= frame_cnt + 16'd1;
                y         <= '0;
                // A pixel arriving on the frame-start cycle occupies x=0
                x         <= vi_de ? X_WIDTH'(1) : '0;
            end else if (vi_de) begin
                if (x != X_MAX) begin
                    x <= x + X_WIDTH'(1);
                end
            end else if (de_d) begin
                x <= '0;
                if (y != Y_MAX) begin
                    y <= y + Y_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_video_window.sv
// tb/tb_video_window.sv - directed self-checking bench for video_window
module tb_video_window;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] cfg_start_x;
    logic [11:0] cfg_start_y;
    logic [11:0] cfg_end_x;
    logic [11:0] cfg_end_y;
    logic [1:0]  cfg_mode;
    logic [23:0] cfg_fill;
    logic        vi_vs;
    logic        vi_de;
    logic [23:0] vi_data;
    logic        vo_vs;
    logic        vo_de;
    logic [23:0] vo_data;
    logic        cfg_err;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int vs_bad = 0;
    logic [23:0] outq[$];

    localparam logic [23:0] GREEN = 24'h00FF00;

    video_window #(
        .DATA_WIDTH(8), .CHANNELS(3), .X_WIDTH(12), .Y_WIDTH(12), .BORDER_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start_x(cfg_start_x), .cfg_start_y(cfg_start_y),
        .cfg_end_x(cfg_end_x), .cfg_end_y(cfg_end_y),
        .cfg_mode(cfg_mode), .cfg_fill(cfg_fill),
        .vi_vs(vi_vs), .vi_de(vi_de), .vi_data(vi_data),
        .vo_vs(vo_vs), .vo_de(vo_de), .vo_data(vo_data),
        .cfg_err(cfg_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pix(input int px, input int py);
        return {8'(py), 8'(px), 8'hA5};
    endfunction

    // Drive one clock of input, then sample outputs 1 time unit after the edge
    task automatic cycle(input logic vs, input logic de, input logic [23:0] d);
        vi_vs   = vs;
        vi_de   = de;
        vi_data = de ? d : 24'h0;
        @(posedge clk);
        #1;
        if (vo_vs !== vs) vs_bad++;
        if (vo_de === 1'b1) outq.push_back(vo_data);
    endtask

    task automatic set_cfg(input int sx, input int sy, input int ex, input int ey,
                           input logic [1:0] mode, input logic [23:0] fill);
        cfg_start_x = 12'(sx);
        cfg_start_y = 12'(sy);
        cfg_end_x   = 12'(ex);
        cfg_end_y   = 12'(ey);
        cfg_mode    = mode;
        cfg_fill    = fill;
    endtask

    // 16x8 frame; cfg_mode is rewritten right after frame start
    task automatic send_frame(input logic [1:0] mode_after);
        outq.delete();
        cycle(1'b1, 1'b0, 24'h0);
        cycle(1'b1, 1'b0, 24'h0);
        cfg_mode = mode_after;
        cycle(1'b0, 1'b0, 24'h0);
        cycle(1'b0, 1'b0, 24'h0);
        for (int ly = 0; ly < 8; ly++) begin
            for (int lx = 0; lx < 16; lx++) cycle(1'b0, 1'b1, pix(lx, ly));
            for (int b = 0; b < 3; b++) cycle(1'b0, 1'b0, 24'h0);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cycle(1'b0, 1'b0, 24'h0);
        cycle(1'b0, 1'b0, 24'h0);
        checks++; if (vo_vs !== 1'b0) begin errors++; $display("FAIL reset_vo_vs got %b want 0", vo_vs); end
        checks++; if (vo_de !== 1'b0) begin errors++; $display("FAIL reset_vo_de got %b want 0", vo_de); end
        checks++; if (vo_data !== 24'h0) begin errors++; $display("FAIL reset_vo_data got %h want 0", vo_data); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 24'h0);
    endtask

    task automatic test_crop;
        int bad = 0;
        set_cfg(4, 2, 12, 6, 2'd1, 24'h0);
        vs_bad = 0;
        send_frame(2'd1);
        foreach (outq[i]) begin
            if (outq[i][15:8] < 4 || outq[i][15:8] > 11 || outq[i][23:16] < 2 || outq[i][23:16] > 5) bad++;
        end
        checks++; if (outq.size() != 32) begin errors++; $display("FAIL crop_count got %0d want 32", outq.size()); end
        checks++; if (outq.size() < 32 || outq[0] !== pix(4, 2)) begin errors++; $display("FAIL crop_first got %h want %h", outq.size() > 0 ? outq[0] : 24'hx, pix(4, 2)); end
        checks++; if (outq.size() < 32 || outq[31] !== pix(11, 5)) begin errors++; $display("FAIL crop_last got %h want %h", outq.size() > 31 ? outq[31] : 24'hx, pix(11, 5)); end
        checks++; if (bad != 0) begin errors++; $display("FAIL crop_outside got %0d want 0", bad); end
        checks++; if (vs_bad != 0) begin errors++; $display("FAIL crop_vs_delay got %0d want 0", vs_bad); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL crop_frame_cnt got %0d want 1", frame_cnt); end
    endtask

    task automatic test_mask;
        int nfill = 0;
        int nin = 0;
        int nbad = 0;
        set_cfg(4, 2, 12, 6, 2'd2, GREEN);
        send_frame(2'd2);
        foreach (outq[i]) begin
            if (outq[i] === GREEN) nfill++;
            else if (outq[i][15:8] >= 4 && outq[i][15:8] <= 11 && outq[i][23:16] >= 2 && outq[i][23:16] <= 5) nin++;
            else nbad++;
        end
        checks++; if (outq.size() != 128) begin errors++; $display("FAIL mask_count got %0d want 128", outq.size()); end
        checks++; if (nfill != 96) begin errors++; $display("FAIL mask_fill got %0d want 96", nfill); end
        checks++; if (nin != 32) begin errors++; $display("FAIL mask_inside got %0d want 32", nin); end
        checks++; if (nbad != 0) begin errors++; $display("FAIL mask_unmasked got %0d want 0", nbad); end
    endtask

    task automatic test_border;
        int nfill = 0;
        int ninner = 0;
        int nwin = 0;
        set_cfg(2, 2, 10, 7, 2'd3, GREEN);
        send_frame(2'd3);
        foreach (outq[i]) begin
            if (outq[i] === GREEN) nfill++;
            else if (outq[i][15:8] >= 2 && outq[i][15:8] <= 9 && outq[i][23:16] >= 2 && outq[i][23:16] <= 6) begin
                nwin++;
                if (outq[i][15:8] >= 4 && outq[i][15:8] <= 7 && outq[i][23:16] == 4) ninner++;
            end
        end
        checks++; if (outq.size() != 128) begin errors++; $display("FAIL border_count got %0d want 128", outq.size()); end
        checks++; if (nfill != 36) begin errors++; $display("FAIL border_fill got %0d want 36", nfill); end
        checks++; if (nwin != 4 || ninner != 4) begin errors++; $display("FAIL border_interior got %0d/%0d want 4/4", nwin, ninner); end
    endtask

    task automatic test_shadow;
        logic [15:0] fc0;
        fc0 = frame_cnt;
        set_cfg(4, 2, 12, 6, 2'd1, 24'h0);
        send_frame(2'd0);
        checks++; if (outq.size() != 32) begin errors++; $display("FAIL shadow_cur_frame got %0d want 32", outq.size()); end
        send_frame(2'd0);
        checks++; if (outq.size() != 128) begin errors++; $display("FAIL shadow_next_frame got %0d want 128", outq.size()); end
        checks++; if (frame_cnt !== fc0 + 16'd2) begin errors++; $display("FAIL shadow_frame_cnt got %0d want %0d", frame_cnt, fc0 + 16'd2); end
    endtask

    task automatic test_invalid;
        set_cfg(10, 2, 10, 6, 2'd1, GREEN);
        send_frame(2'd1);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL invalid_cfg_err got %b want 1", cfg_err); end
        checks++; if (outq.size() != 128) begin errors++; $display("FAIL invalid_bypass_count got %0d want 128", outq.size()); end
        checks++; if (outq.size() == 0 || outq[0] !== pix(0, 0)) begin errors++; $display("FAIL invalid_bypass_data got %h want %h", outq.size() > 0 ? outq[0] : 24'hx, pix(0, 0)); end
        set_cfg(4, 2, 12, 6, 2'd1, GREEN);
        send_frame(2'd1);
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL invalid_clear got %b want 0", cfg_err); end
        checks++; if (outq.size() != 32) begin errors++; $display("FAIL invalid_recover got %0d want 32", outq.size()); end
    endtask

    task automatic test_reset_mid;
        set_cfg(4, 2, 12, 6, 2'd1, 24'h0);
        cycle(1'b1, 1'b0, 24'h0);
        cycle(1'b1, 1'b0, 24'h0);
        cycle(1'b0, 1'b0, 24'h0);
        for (int ly = 0; ly < 3; ly++) begin
            for (int lx = 0; lx < 16; lx++) cycle(1'b0, 1'b1, pix(lx, ly));
            for (int b = 0; b < 3; b++) cycle(1'b0, 1'b0, 24'h0);
        end
        for (int lx = 0; lx < 8; lx++) cycle(1'b0, 1'b1, pix(lx, 3));
        rst_n = 1'b0;
        cycle(1'b0, 1'b0, 24'h0);
        rst_n = 1'b1;
        checks++; if (vo_de !== 1'b0 || vo_data !== 24'h0 || vo_vs !== 1'b0) begin errors++; $display("FAIL midreset_outputs got %b/%h/%b want 0/0/0", vo_de, vo_data, vo_vs); end
        checks++; if (frame_cnt !== 16'd0 || cfg_err !== 1'b0) begin errors++; $display("FAIL midreset_status got %0d/%b want 0/0", frame_cnt, cfg_err); end
        outq.delete();
        for (int lx = 8; lx < 16; lx++) cycle(1'b0, 1'b1, pix(lx, 3));
        for (int b = 0; b < 3; b++) cycle(1'b0, 1'b0, 24'h0);
        for (int ly = 4; ly < 8; ly++) begin
            for (int lx = 0; lx < 16; lx++) cycle(1'b0, 1'b1, pix(lx, ly));
            for (int b = 0; b < 3; b++) cycle(1'b0, 1'b0, 24'h0);
        end
        checks++; if (outq.size() != 72) begin errors++; $display("FAIL midreset_bypass_count got %0d want 72", outq.size()); end
        checks++; if (outq.size() == 0 || outq[0] !== pix(8, 3)) begin errors++; $display("FAIL midreset_bypass_data got %h want %h", outq.size() > 0 ? outq[0] : 24'hx, pix(8, 3)); end
        send_frame(2'd1);
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL midreset_frame_cnt got %0d want 1", frame_cnt); end
        checks++; if (outq.size() != 32) begin errors++; $display("FAIL midreset_crop_resumes got %0d want 32", outq.size()); end
    endtask

    task automatic test_vs_de_same_cycle;
        set_cfg(0, 0, 1, 1, 2'd1, 24'h0);
        cycle(1'b0, 1'b0, 24'h0);
        cycle(1'b1, 1'b1, pix(0, 0));
        checks++; if (vo_de !== 1'b1 || vo_data !== pix(0, 0)) begin errors++; $display("FAIL samecycle_first got %b/%h want 1/%h", vo_de, vo_data, pix(0, 0)); end
        cycle(1'b1, 1'b1, pix(1, 0));
        checks++; if (vo_de !== 1'b0 || vo_data !== 24'h0) begin errors++; $display("FAIL samecycle_second got %b/%h want 0/0", vo_de, vo_data); end
        cycle(1'b0, 1'b0, 24'h0);
        cycle(1'b0, 1'b0, 24'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        vi_vs = 1'b0;
        vi_de = 1'b0;
        vi_data = 24'h0;
        set_cfg(0, 0, 0, 0, 2'd0, 24'h0);
        test_reset();
        test_crop();
        test_mask();
        test_border();
        test_shadow();
        test_invalid();
        test_reset_mid();
        test_vs_de_same_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
